// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Oversampled UART receiver with 3-sample majority voting per bit, configurable
// frame format and a first-word-fall-through receive FIFO.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> one parity bit follows the data bits, parity_err is live
//   undefined -> no parity bit, parity_err tied 0, PARITY_ODD ignored
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   rx         : serial line (asynchronous, idle high)
//   rd_data    : FIFO head entry (0 while the FIFO is empty)
//   rd_valid   : FIFO not empty
//   rd_ready   : consumer accepts the head entry
//   fifo_count : current FIFO occupancy
//   err_clr    : clears all sticky error flags
//   frame_err  : sticky, a stop bit was sampled low
//   parity_err : sticky, parity mismatch
//   overrun    : sticky, a received byte was dropped on a full FIFO
//   dbg_state  : receiver FSM state (0 idle, 1 start, 2 data, 3 parity, 4 stop)
//
// Read handshake: rd_data/rd_valid are presented whenever the FIFO holds data;
// an entry is consumed on every rising clk edge where rd_valid && rd_ready.
// rd_data is held stable while rd_valid && !rd_ready.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    input  logic                              err_clr,
    output logic                              frame_err,
    output logic                              parity_err,
    output logic                              overrun,
    output logic [2:0]                        dbg_state
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(FIFO_DEPTH + 1);

    // Tick positions inside one bit period (ticks numbered 1..OVERSAMPLE).
    localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] MID_LATE  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] BIT_END   = SW'(OVERSAMPLE);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 8 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_fifo: unsupported parameter combination");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
    localparam logic PAR_INV = (PARITY_ODD != 0);
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    state_t                 state;
    logic                   rx_s1, rx_s2, rx_prev;
    logic                   fall;
    logic [TW-1:0]          tick_cnt;
    logic                   tick;
    logic                   start_go;
    logic [1:0]             smp;
    logic                   vote;
    logic [SW-1:0]          bit_tick;
    logic [SW-1:0]          nt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   stop_bad;
    logic                   stop_bad_now;
    logic                   last_stop;
    logic                   push_pend;
    logic [DATA_BITS-1:0]   push_data;

    // ---------------------------------------------------------------- sync
    // rx_prev is the previous synchronized level, used for 1->0 edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign fall     = rx_prev & ~rx_s2;
    assign start_go = (state == ST_IDLE) && fall;

    // -------------------------------------------------------- tick generator
    // Free-running, but re-phased on every start edge so the sample points
    // line up with the start bit of the frame being received.
    assign tick = (tick_cnt == TW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (start_go || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Two previous tick samples; together with the current rx_s2 they form the
    // three-sample majority window that ends on the current tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp <= 2'b11;
        end else if (tick) begin
            smp <= {smp[0], rx_s2};
        end
    end

    assign vote         = (smp[1] & smp[0]) | (smp[1] & rx_s2) | (smp[0] & rx_s2);
    assign nt           = bit_tick + SW'(1);
    assign stop_bad_now = stop_bad | ~vote;
    assign last_stop    = (bit_idx == 3'(STOP_BITS - 1));

    // ------------------------------------------------------------------ FSM
    // START votes ticks OS/2-2..OS/2 and decides at OS/2; DATA, PARITY and
    // STOP vote ticks OS/2-1..OS/2+1 and decide at OS/2+1. The last stop bit
    // returns to IDLE at its decision tick so a new start edge is caught at once.
`ifdef UART_RX_PARITY_EN
    logic par_err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bit_tick  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            stop_bad  <= 1'b0;
            push_pend <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            push_pend <= 1'b0;
            // Clears first; a same-cycle set below overrides them.
            if (err_clr) begin
                frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                par_err_q <= 1'b0;
`endif
            end
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state    <= ST_START;
                        bit_tick <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        bit_tick <= (nt == BIT_END) ? '0 : nt;
                        if (nt == MID_START && vote) begin
                            state <= ST_IDLE;
                        end else if (nt == BIT_END) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        bit_tick <= (nt == BIT_END) ? '0 : nt;
                        if (nt == MID_LATE) begin
                            shreg <= {vote, shreg[DATA_BITS-1:1]};
                        end
                        if (nt == BIT_END) begin
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
                                bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= ST_PARITY;
`else
                                state   <= ST_STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        bit_tick <= (nt == BIT_END) ? '0 : nt;
                        if (nt == MID_LATE && (vote != ((^shreg) ^ PAR_INV))) begin
                            par_err_q <= 1'b1;
                        end
                        if (nt == BIT_END) begin
                            state   <= ST_STOP;
                            bit_idx <= '0;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        bit_tick <= (nt == BIT_END) ? '0 : nt;
                        if (nt == MID_LATE) begin
                            if (last_stop) begin
                                state    <= ST_IDLE;
                                stop_bad <= 1'b0;
                                if (stop_bad_now) begin
                                    frame_err <= 1'b1;
                                end else begin
                                    push_pend <= 1'b1;
                                    push_data <= shreg;
                                end
                            end else begin
                                stop_bad <= stop_bad_now;
                            end
                        end
                        if (nt == BIT_END) begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign dbg_state = state;

    // ----------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 pop, full, push_ok;

    assign pop     = rd_valid && rd_ready;
    assign full    = (fifo_count == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_pend && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (push_pend && full && !pop) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign rd_valid = (fifo_count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

endmodule
